command_arbiter: RTL and testbench

COMMAND_ARBITER -- requirements
Module: command_arbiter

---
 rtl/command_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_command_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_arbiter.sv
// Two-requester command arbiter: grants read/write requests against PSL credits and tags.
// Optional response-tag checking is enabled by defining COMMAND_ARBITER_TAG_CHECK_EN.
module command_arbiter #(
    parameter int NTAGS    = 16,
    parameter int CMD_SIZE = 128
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [7:0]        croom,
    input  logic              rd_valid,
    input  logic [63:0]       rd_addr,
    output logic              rd_ready,
    output logic [7:0]        rd_tag,
    input  logic              wr_valid,
    input  logic [63:0]       wr_addr,
    output logic              wr_ready,
    output logic [7:0]        wr_tag,
    output logic              cmd_valid,
    output logic [12:0]       cmd_com,
    output logic [7:0]        cmd_tag,
    output logic [63:0]       cmd_ea,
    output logic [11:0]       cmd_size,
    input  logic              rsp_valid,
    input  logic [7:0]        rsp_tag,
    input  logic signed [8:0] rsp_credits,
    output logic              idle,
    output logic              tag_error
);

    localparam int TW = (NTAGS > 1) ? $clog2(NTAGS) : 1;
    localparam logic [7:0]  NTAGS_B = 8'(NTAGS);
    localparam logic [12:0] COM_RD  = 13'h0A00;
    localparam logic [12:0] COM_WR  = 13'h0D00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [NTAGS-1:0]  busy_q, busy_d;
    logic signed [8:0] credits_q, credits_d;
    logic              prio_wr_q, prio_wr_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [12:0]       cmd_com_q, cmd_com_d;
    logic [7:0]        cmd_tag_q, cmd_tag_d;
    logic [63:0]       cmd_ea_q, cmd_ea_d;
    logic [11:0]       cmd_size_q;

    logic [TW-1:0]     free_idx;
    logic              any_free;
    logic              can_issue;
    logic              acc_rd, acc_wr, acc;
    logic [TW-1:0]     rsp_idx;
    logic              rsp_in_range;
    logic              rsp_ok;

    // Lowest-index free tag from the pre-update busy vector.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NTAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                any_free = 1'b1;
                free_idx = TW'(i);
            end
        end
    end

    // A response only counts when it names an in-range, outstanding tag.
    always_comb begin
        rsp_idx      = rsp_tag[TW-1:0];
        rsp_in_range = rsp_tag < NTAGS_B;
        rsp_ok       = rsp_valid && rsp_in_range && busy_q[rsp_idx];
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (enable) state_d = S_LOAD;
            S_LOAD:  state_d = S_RUN;
            S_RUN:   if (!enable) state_d = S_DRAIN;
            S_DRAIN: begin
                if (enable) begin
                    state_d = S_RUN;
                end else if (busy_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: round-robin grant, at most one ready per cycle.
    always_comb begin
        can_issue = (state_q == S_RUN) && (credits_q > 9'sd0) && any_free;
        rd_ready  = can_issue && rd_valid && (!wr_valid || !prio_wr_q);
        wr_ready  = can_issue && wr_valid && (!rd_valid || prio_wr_q);
        idle      = (state_q == S_IDLE) && (busy_q == '0);
        rd_tag    = 8'(free_idx);
        wr_tag    = 8'(free_idx);
    end

    assign acc_rd = rd_valid && rd_ready;
    assign acc_wr = wr_valid && wr_ready;
    assign acc    = acc_rd || acc_wr;

    // Next-state for tags, credits, priority and the registered command.
    always_comb begin
        busy_d = busy_q;
        if (rsp_ok) busy_d[rsp_idx] = 1'b0;
        if (acc) busy_d[free_idx] = 1'b1;

        credits_d = (state_q == S_LOAD) ? $signed({1'b0, croom}) : credits_q;
        if (acc) credits_d = credits_d - 9'sd1;
        if (rsp_ok) credits_d = credits_d + rsp_credits;

        prio_wr_d = prio_wr_q;
        if (acc_rd) prio_wr_d = 1'b1;
        if (acc_wr) prio_wr_d = 1'b0;

        cmd_valid_d = acc;
        cmd_com_d   = cmd_com_q;
        cmd_tag_d   = cmd_tag_q;
        cmd_ea_d    = cmd_ea_q;
        if (acc_rd) begin
            cmd_com_d = COM_RD;
            cmd_tag_d = 8'(free_idx);
            cmd_ea_d  = rd_addr;
        end else if (acc_wr) begin
            cmd_com_d = COM_WR;
            cmd_tag_d = 8'(free_idx);
            cmd_ea_d  = wr_addr;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_q      <= '0;
            credits_q   <= '0;
            prio_wr_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_com_q   <= '0;
            cmd_tag_q   <= '0;
            cmd_ea_q    <= '0;
            cmd_size_q  <= 12'(CMD_SIZE);
        end else begin
            busy_q      <= busy_d;
            credits_q   <= credits_d;
            prio_wr_q   <= prio_wr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_com_q   <= cmd_com_d;
            cmd_tag_q   <= cmd_tag_d;
            cmd_ea_q    <= cmd_ea_d;
            cmd_size_q  <= 12'(CMD_SIZE);
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_com   = cmd_com_q;
    assign cmd_tag   = cmd_tag_q;
    assign cmd_ea    = cmd_ea_q;
    assign cmd_size  = cmd_size_q;

`ifdef COMMAND_ARBITER_TAG_CHECK_EN
    logic tag_err_q;

    // Sticky flag for responses naming an unknown or idle tag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tag_err_q <= 1'b0;
        end else if (rsp_valid && !rsp_ok) begin
            tag_err_q <= 1'b1;
        end
    end

    assign tag_error = tag_err_q;
`else
    assign tag_error = 1'b0;
`endif

endmodule

// File: tb/tb_command_arbiter.sv
// Scoreboard bench for command_arbiter: directed scenarios push expected
// commands, a negedge monitor pops and compares every cmd_valid pulse.
module tb_command_arbiter;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [7:0]        croom;
    logic              rd_valid;
    logic [63:0]       rd_addr;
    logic              rd_ready;
    logic [7:0]        rd_tag;
    logic              wr_valid;
    logic [63:0]       wr_addr;
    logic              wr_ready;
    logic [7:0]        wr_tag;
    logic              cmd_valid;
    logic [12:0]       cmd_com;
    logic [7:0]        cmd_tag;
    logic [63:0]       cmd_ea;
    logic [11:0]       cmd_size;
    logic              rsp_valid;
    logic [7:0]        rsp_tag;
    logic signed [8:0] rsp_credits;
    logic              idle;
    logic              tag_error;

    localparam logic [12:0] RD = 13'h0A00;
    localparam logic [12:0] WR = 13'h0D00;

    typedef struct packed {
        logic [12:0] com;
        logic [7:0]  tag;
        logic [63:0] ea;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    command_arbiter #(.NTAGS(16), .CMD_SIZE(128)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .croom(croom),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_tag(rd_tag),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_ready(wr_ready), .wr_tag(wr_tag),
        .cmd_valid(cmd_valid), .cmd_com(cmd_com), .cmd_tag(cmd_tag),
        .cmd_ea(cmd_ea), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_credits(rsp_credits),
        .idle(idle), .tag_error(tag_error)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [12:0] com, input int tag, input logic [63:0] ea);
        exp_t e;
        e.com = com;
        e.tag = 8'(tag);
        e.ea  = ea;
        q.push_back(e);
    endtask

    // Monitor: every command pulse must match the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (cmd_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_unexpected: got tag %0h com %0h expected none", cmd_tag, cmd_com);
            end else begin
                e = q.pop_front();
                chk("cmd_com", 64'(cmd_com), 64'(e.com));
                chk("cmd_tag", 64'(cmd_tag), 64'(e.tag));
                chk("cmd_ea", cmd_ea, e.ea);
                chk("cmd_size", 64'(cmd_size), 64'd128);
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0; enable = 1'b0; croom = 8'd0;
        rd_valid = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0;
        rsp_valid = 1'b0; rsp_tag = '0; rsp_credits = '0;
        q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic settle();
        repeat (3) @(negedge clock);
        chk("queue_drained", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int  n;
        bit  sent;
        bit  found;

        // Reset state
        do_reset();
        @(negedge clock);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_cmd_com", 64'(cmd_com), 64'd0);
        chk("rst_cmd_tag", 64'(cmd_tag), 64'd0);
        chk("rst_cmd_ea", cmd_ea, 64'd0);
        chk("rst_cmd_size", 64'(cmd_size), 64'd128);
        chk("rst_tag_error", 64'(tag_error), 64'd0);
        rd_valid = 1'b1; wr_valid = 1'b1;
        #1 chk("rst_no_ready", 64'({rd_ready, wr_ready}), 64'd0);

        // Four credits, read held: tags 0..3 then stall
        do_reset();
        croom = 8'd4; enable = 1'b1; rd_valid = 1'b1; rd_addr = 64'h1000;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (rd_ready) begin
                chk("cr4_tag", 64'(rd_tag), 64'(n));
                push(RD, n, 64'h1000);
                n++;
            end
        end
        chk("cr4_count", 64'(n), 64'd4);
        chk("cr4_stall", 64'(rd_ready), 64'd0);
        settle();

        // Both requesters valid: alternating read/write grants
        do_reset();
        croom = 8'd8; enable = 1'b1;
        rd_valid = 1'b1; rd_addr = 64'h2000;
        wr_valid = 1'b1; wr_addr = 64'h3000;
        n = 0;
        for (int c = 0; c < 30 && n < 8; c++) begin
            @(negedge clock);
            if (rd_ready || wr_ready) begin
                chk("rr_one_ready", 64'(rd_ready && wr_ready), 64'd0);
                chk("rr_rd_grant", 64'(rd_ready), 64'(n % 2 == 0));
                if (n % 2 == 0) push(RD, n, 64'h2000);
                else push(WR, n, 64'h3000);
                n++;
            end
        end
        chk("rr_count", 64'(n), 64'd8);
        @(negedge clock);
        rd_valid = 1'b0; wr_valid = 1'b0;
        settle();

        // Acceptance and +2 credit response on the same edge
        do_reset();
        croom = 8'd2; enable = 1'b1; rd_valid = 1'b1; rd_addr = 64'h4000;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            rsp_valid = 1'b0;
            if (rd_ready) begin
                case (n)
                    0: begin chk("cr_tag0", 64'(rd_tag), 64'd0); push(RD, 0, 64'h4000); end
                    1: begin
                        chk("cr_tag1", 64'(rd_tag), 64'd1); push(RD, 1, 64'h4000);
                        rsp_valid = 1'b1; rsp_tag = 8'd0; rsp_credits = 9'sd2;
                    end
                    2: begin chk("cr_tag2", 64'(rd_tag), 64'd0); push(RD, 0, 64'h4000); end
                    3: begin chk("cr_tag3", 64'(rd_tag), 64'd2); push(RD, 2, 64'h4000); end
                    default: chk("cr_extra", 64'(n), 64'd3);
                endcase
                n++;
            end
        end
        chk("cr_count", 64'(n), 64'd4);
        settle();

        // All 16 tags busy, tag 5 returns and is reused next cycle
        do_reset();
        croom = 8'd20; enable = 1'b1; rd_valid = 1'b1; rd_addr = 64'h5000;
        n = 0; sent = 1'b0;
        for (int c = 0; c < 60 && n < 17; c++) begin
            @(negedge clock);
            rsp_valid = 1'b0;
            if (rd_ready) begin
                chk("full_tag", 64'(rd_tag), (n < 16) ? 64'(n) : 64'd5);
                push(RD, (n < 16) ? n : 5, 64'h5000);
                n++;
            end else if (n == 16 && !sent) begin
                rsp_valid = 1'b1; rsp_tag = 8'd5; rsp_credits = 9'sd0;
                sent = 1'b1;
                #1 chk("full_no_ready", 64'(rd_ready), 64'd0);
            end
        end
        chk("full_count", 64'(n), 64'd17);
        @(negedge clock);
        rsp_valid = 1'b0;
        chk("full_again", 64'(rd_ready), 64'd0);
        rd_valid = 1'b0;
        settle();

        // Drain with three tags outstanding
        do_reset();
        croom = 8'd8; enable = 1'b1; rd_valid = 1'b1; rd_addr = 64'h6000;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge clock);
            if (rd_ready) begin
                push(RD, n, 64'h6000);
                n++;
                if (n == 3) enable = 1'b0;
            end
        end
        chk("drain_count", 64'(n), 64'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("drain_no_ready", 64'(rd_ready || wr_ready), 64'd0);
            chk("drain_not_idle", 64'(idle), 64'd0);
            rsp_valid = 1'b1; rsp_tag = 8'(k); rsp_credits = 9'sd1;
        end
        @(negedge clock);
        rsp_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 5 && !found; c++) begin
            @(negedge clock);
            found = idle;
        end
        chk("drain_idle", 64'(found), 64'd1);
        chk("drain_q", 64'(q.size()), 64'd0);

        // Reset mid-operation suppresses the pending pulse
        do_reset();
        croom = 8'd4; enable = 1'b1; rd_valid = 1'b1; rd_addr = 64'h7000;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clock);
            found = rd_ready;
        end
        chk("mid_ready_seen", 64'(found), 64'd1);
        reset_n = 1'b0;
        @(negedge clock);
        chk("mid_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("mid_idle", 64'(idle), 64'd1);
        chk("mid_no_ready", 64'(rd_ready), 64'd0);
        rd_valid = 1'b0; enable = 1'b0; reset_n = 1'b1;
        @(negedge clock);
        chk("mid_no_pulse", 64'(cmd_valid), 64'd0);

        // Response for a free tag
        do_reset();
        @(negedge clock);
        rsp_valid = 1'b1; rsp_tag = 8'd7; rsp_credits = 9'sd1;
        @(negedge clock);
        rsp_valid = 1'b0;
`ifdef COMMAND_ARBITER_TAG_CHECK_EN
        chk("terr_set", 64'(tag_error), 64'd1);
        repeat (4) @(negedge clock);
        chk("terr_sticky", 64'(tag_error), 64'd1);
        reset_n = 1'b0;
        @(negedge clock);
        chk("terr_clear", 64'(tag_error), 64'd0);
        reset_n = 1'b1;
`else
        chk("terr_tied", 64'(tag_error), 64'd0);
        chk("terr_idle", 64'(idle), 64'd1);
        rsp_valid = 1'b1; rsp_tag = 8'd200;
        @(negedge clock);
        rsp_valid = 1'b0;
        chk("terr_range_tied", 64'(tag_error), 64'd0);
`endif
        @(negedge clock);
        chk("end_queue", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
